// File: rtl/core_pkg.sv
// Shared definitions for the core data-memory controller: access size
// encodings, the controller state enum and the default bus timeout.
package core_pkg;

  // Access size as carried on i_data_mask (2'b11 is handled as a word)
  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  // Cycles a transaction may spend in ISSUE or WAIT_R before a bus error
  localparam int DMEM_TIMEOUT = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    WAIT_R = 3'd2,
    DONE   = 3'd3,
    MIS    = 3'd4
  } dmem_state_e;

endpackage

// File: rtl/core_dmem_lane.sv
// Lane steering for a data access: byte enables, store data replicated
// across every lane the access may land in, and the alignment check.
module core_dmem_lane
  import core_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic [31:0] data,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic        misaligned
);

  // Decode size and low address bits into lanes and alignment
  always_comb begin
    be         = 4'b0000;
    wdata      = data;
    misaligned = 1'b0;
    case (size)
      SIZE_B: begin
        be    = 4'b0001 << addr_lo;
        wdata = {4{data[7:0]}};
      end
      SIZE_H: begin
        be         = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata      = {2{data[15:0]}};
        misaligned = addr_lo[0];
      end
      default: begin
        be         = 4'b1111;
        wdata      = data;
        misaligned = |addr_lo;
      end
    endcase
  end

endmodule

// File: rtl/core_dmem_ctrl.sv
// Data-memory controller between the core EX stage and the memory bus.
// Converts a single-cycle core request into a valid/ready bus request,
// waits for load data, traps misaligned accesses and times out a silent bus.
//
// Bus handshake: o_mem_valid is held high in ISSUE with address, byte
// enables, write data and write strobe frozen until a cycle where
// i_mem_ready is also high; that cycle transfers the request. Load data is
// taken on any cycle with i_mem_rvalid while waiting for it (including the
// accepting cycle itself); rvalid at any other time is dropped.
module core_dmem_ctrl
  import core_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = DMEM_TIMEOUT
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_data_req,
  input  logic            i_data_rd_en,
  input  logic            i_data_wr_en,
  input  logic [XLEN-1:0] i_data_addr,
  input  logic [XLEN-1:0] i_data_wr_data,
  input  logic [1:0]      i_data_mask,
  output logic [XLEN-1:0] o_data_rd_data,
  output logic            o_data_ack,
  output logic            o_stall,
  output logic            o_misaligned,
  output logic            o_bus_err,
  output logic [XLEN-1:0] o_mem_addr,
  output logic [3:0]      o_mem_be,
  output logic [XLEN-1:0] o_mem_wdata,
  output logic            o_mem_we,
  output logic            o_mem_valid,
  input  logic            i_mem_ready,
  input  logic [XLEN-1:0] i_mem_rdata,
  input  logic            i_mem_rvalid
);

  localparam int CW = $clog2(TIMEOUT + 1);
  // Count value seen during the last allowed waiting cycle; the counter
  // steps to TIMEOUT on the same edge that abandons the transaction.
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

  dmem_state_e     state;
  dmem_state_e     state_n;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] rd_q;
  logic [XLEN-1:0] rd_n;
  logic [3:0]      be_q;
  logic            we_q;
  logic            err_q;
  logic            err_n;
  logic [CW-1:0]   cnt;

  logic [3:0]      lane_be;
  logic [XLEN-1:0] lane_wdata;
  logic            lane_mis;
  logic            start;
  logic            tmo;

  core_dmem_lane u_lane (
    .addr_lo    (i_data_addr[1:0]),
    .size       (i_data_mask),
    .data       (i_data_wr_data),
    .be         (lane_be),
    .wdata      (lane_wdata),
    .misaligned (lane_mis)
  );

  assign start = i_data_req && (i_data_rd_en || i_data_wr_en);
  assign tmo   = (cnt == TMO_LAST);

  // Next-state logic plus the value/error flag latched when entering DONE
  always_comb begin
    state_n = state;
    rd_n    = '0;
    err_n   = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_n = lane_mis ? MIS : ISSUE;
      end
      ISSUE: begin
        if (i_mem_ready) begin
          if (we_q) begin
            state_n = DONE;
          end else if (i_mem_rvalid) begin
            state_n = DONE;
            rd_n    = i_mem_rdata;
          end else begin
            state_n = WAIT_R;
          end
        end else if (tmo) begin
          state_n = DONE;
          err_n   = 1'b1;
        end
      end
      WAIT_R: begin
        if (i_mem_rvalid) begin
          state_n = DONE;
          rd_n    = i_mem_rdata;
        end else if (tmo) begin
          state_n = DONE;
          err_n   = 1'b1;
        end
      end
      DONE:    state_n = IDLE;
      MIS:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_n;
  end

  // Request capture, load-return capture and wait-state counter
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= 4'b0000;
      we_q    <= 1'b0;
      rd_q    <= '0;
      err_q   <= 1'b0;
      cnt     <= '0;
    end else begin
      if (state == IDLE && start) begin
        addr_q  <= {i_data_addr[XLEN-1:2], 2'b00};
        wdata_q <= lane_wdata;
        be_q    <= lane_be;
        we_q    <= i_data_wr_en;
      end
      if (state != DONE && state_n == DONE) begin
        rd_q  <= rd_n;
        err_q <= err_n;
      end
      if ((state_n == ISSUE && state != ISSUE) ||
          (state_n == WAIT_R && state != WAIT_R)) begin
        cnt <= '0;
      end else if (state == ISSUE || state == WAIT_R) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Stall is gated by reset so a request held during reset is not seen
  assign o_stall        = i_rst_n && ((state == IDLE && start) ||
                                      state == ISSUE || state == WAIT_R);
  assign o_mem_valid    = (state == ISSUE);
  assign o_mem_we       = we_q && (state == ISSUE);
  assign o_mem_addr     = addr_q;
  assign o_mem_be       = be_q;
  assign o_mem_wdata    = wdata_q;
  assign o_data_ack     = (state == DONE) || (state == MIS);
  assign o_misaligned   = (state == MIS);
  assign o_bus_err      = (state == DONE) && err_q;
  assign o_data_rd_data = rd_q;

endmodule

// File: doc/core_dmem_ctrl.md
Name: core_dmem_ctrl

Overview:
Sits directly downstream of the core's EX-stage data interface and upstream of the data memory/bus. It turns the single-cycle core request into a ready/valid bus transaction with wait states: byte-enable generation, store-lane replication, misalignment trapping, load-return capture and a timeout. It drives a stall back to the core so EX/WB hold while a transaction is outstanding. Returned load data is the raw 32-bit word in memory lane positions; the WB stage performs extraction and sign/zero extension.

Parameters:
XLEN, 32, data/address width (only 32 supported)
TIMEOUT, 16, max cycles waiting in ISSUE or WAIT_R before bus error; counter width $clog2(TIMEOUT+1)

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_data_req  in  1  core request qualifier
i_data_rd_en  in  1  load (from EX mem_read)
i_data_wr_en  in  1  store
i_data_addr  in  XLEN  byte address
i_data_wr_data  in  XLEN  store data, right-aligned
i_data_mask  in  2  size: 00 byte, 01 half, 10 word, 11 treated as word
o_data_rd_data  out  XLEN  load word, valid with o_data_ack
o_data_ack  out  1  one-cycle completion pulse
o_stall  out  1  hold EX/WB pipeline registers
o_misaligned  out  1  one-cycle pulse with ack, access not issued
o_bus_err  out  1  one-cycle pulse with ack on timeout
o_mem_addr  out  XLEN  word address ({addr[31:2],2'b00})
o_mem_be  out  4  byte enables
o_mem_wdata  out  XLEN  lane-replicated store data
o_mem_we  out  1  write strobe
o_mem_valid  out  1  request valid
i_mem_ready  in  1  request accepted
i_mem_rdata  in  XLEN  read data
i_mem_rvalid  in  1  read data valid

Behaviour:
- Reset: all outputs 0, state IDLE, captured request/data registers 0, timeout counter 0. Reset is honoured mid-transaction: o_mem_valid drops asynchronously and no ack is produced.
- Transaction start: IDLE and i_data_req && (i_data_rd_en || i_data_wr_en). If both enables are set, the access is a store.
- o_stall is combinational: 1 in IDLE when a transaction starts, and 1 in ISSUE and WAIT_R; 0 in DONE and in idle IDLE.
- IDLE: on start, register addr, BE, wdata, we and size. Misaligned (half with addr[0]=1, word with addr[1:0]!=0) -> MIS; otherwise -> ISSUE.
- ISSUE: o_mem_valid=1, and the addr/be/wdata/we outputs stay stable until i_mem_ready. On valid&&ready: store -> DONE, load -> WAIT_R. If i_mem_rvalid arrives in the same cycle as ready for a load, capture the data and go straight to DONE.
- WAIT_R: on i_mem_rvalid, capture i_mem_rdata -> DONE. rvalid outside WAIT_R (or the ISSUE case above) is ignored.
- DONE: o_data_ack=1 and o_data_rd_data = captured word (0 for stores) -> IDLE. The core advances on this edge, so a new request is evaluated in the following IDLE cycle (minimum 3 cycles per access with zero-wait memory).
- MIS: o_data_ack=1 and o_misaligned=1, o_mem_valid never asserted -> IDLE.
- Timeout: the counter clears on entering ISSUE or WAIT_R and increments each cycle there. At count==TIMEOUT: o_mem_valid drops and the state goes to DONE with o_bus_err=1 and rd_data=0.
- BE/wdata encoding:
  - byte: be = 1<<addr[1:0], wdata = {4{d[7:0]}}
  - half: be = addr[1] ? 1100 : 0011, wdata = {2{d[15:0]}}
  - word: be = 1111, wdata = d
- o_data_rd_data holds its value until the next capture.

Decomposition:
- core_pkg: size encodings SIZE_B/SIZE_H/SIZE_W, the dmem state enum (IDLE, ISSUE, WAIT_R, DONE, MIS) and the default TIMEOUT.
- Sub-module core_dmem_lane (combinational): addr+size+data -> be, replicated wdata and the misaligned flag.
- The FSM, timeout counter and capture registers stay in core_dmem_ctrl.

Test Plan:
- Store byte, addr 0x103, data 0xA5, zero-wait ready -> o_mem_be=1000, wdata=0xA5A5A5A5, addr 0x100; ack 2 cycles after request; o_stall high for 2 cycles.
- Load word, addr 0x200, ready after 2 cycles, rvalid 3 cycles later with 0xDEADBEEF -> o_data_rd_data=0xDEADBEEF with ack; o_mem_valid held stable throughout ISSUE.
- Half store at 0x201 -> o_misaligned and ack 1 cycle later, o_mem_valid never 1, o_stall high 1 cycle.
- Load with ready never asserted, TIMEOUT=16 -> o_bus_err+ack after 16 ISSUE cycles, rd_data=0, then the next request is accepted normally.
- Back-to-back half loads at 0x10 and 0x12 with zero-wait and same-cycle rvalid -> two acks 3 cycles apart, BE 0011 then 1100.
- Reset asserted while in WAIT_R -> all outputs 0 immediately; a late rvalid after reset is ignored; no ack.
